// File: rtl/dvi_pixel_stage_if.sv
// Pixel FIFO handshake between the upstream producer and the DVI pixel stage.
// The producer owns data/valid; the stage owns ready.
interface dvi_pixel_stage_if #(
  parameter int PIX_W = 24
);
  logic [PIX_W-1:0] pix_data;
  logic             pix_valid;
  logic             pix_ready;

  modport master (
    output pix_data,
    output pix_valid,
    input  pix_ready
  );

  modport slave (
    input  pix_data,
    input  pix_valid,
    output pix_ready
  );
endinterface

// File: rtl/dvi_pixel_stage.sv
// Pixel stage behind the DVI sync generator: pops FIFO pixels in active
// cycles, aligns rgb/hs/vs/de over two stages, tracks underflow and frame size.
module dvi_pixel_stage #(
  parameter int               PIX_W      = 24,
  parameter logic [PIX_W-1:0] BORDER_RGB = 24'h000000,
  parameter logic [PIX_W-1:0] UFLOW_RGB  = 24'hFF00FF,
  parameter int               CNT_W      = 16,
  parameter int               FCNT_W     = 20
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              vs_in,
  input  logic              hs_in,
  input  logic              border_in,
  dvi_pixel_stage_if.slave  pix,
  output logic              frame_start,
  output logic [PIX_W-1:0]  rgb_out,
  output logic              hs_out,
  output logic              vs_out,
  output logic              de_out,
  output logic [CNT_W-1:0]  uflow_cnt,
  output logic              uflow_sticky,
  output logic [FCNT_W-1:0] frame_pixels
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    RUN
  } state_t;

  typedef enum logic [1:0] {
    SEL_ZERO,
    SEL_BORDER,
    SEL_PIX,
    SEL_UFLOW
  } sel_t;

  state_t            state;
  sel_t              sel_d;
  sel_t              s1_sel;
  logic              vs_q;
  logic              s1_hs;
  logic              s1_vs;
  logic              s1_de;
  logic [PIX_W-1:0]  s1_pix;
  logic [PIX_W-1:0]  rgb_d;
  logic [FCNT_W-1:0] fcnt;
  logic [FCNT_W-1:0] fcnt_inc;
  logic              vs_rise;
  logic              vs_fall;
  logic              act;
  logic              run;
  logic              pop;
  logic              uflow;

  assign vs_rise = vs_in & ~vs_q;
  assign vs_fall = ~vs_in & vs_q;
  assign act     = ~border_in & ~hs_in & ~vs_in;
  assign run     = (state == RUN);

  // ready depends only on state and timing, never on pix_valid
  assign pix.pix_ready = run & act;
  assign pop           = pix.pix_ready & pix.pix_valid;
  assign uflow         = pix.pix_ready & ~pix.pix_valid;

  assign fcnt_inc = (pop && fcnt != '1) ? fcnt + FCNT_W'(1) : fcnt;

  always_comb begin
    sel_d = SEL_BORDER;
    unique case (1'b1)
      state == IDLE: sel_d = SEL_ZERO;
      pop:           sel_d = SEL_PIX;
      uflow:         sel_d = SEL_UFLOW;
      default:       sel_d = SEL_BORDER;
    endcase
  end

  always_comb begin
    rgb_d = '0;
    unique case (s1_sel)
      SEL_BORDER: rgb_d = BORDER_RGB;
      SEL_PIX:    rgb_d = s1_pix;
      SEL_UFLOW:  rgb_d = UFLOW_RGB;
      default:    rgb_d = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state        <= IDLE;
      vs_q         <= 1'b0;
      frame_start  <= 1'b0;
      s1_sel       <= SEL_ZERO;
      s1_pix       <= '0;
      s1_hs        <= 1'b0;
      s1_vs        <= 1'b0;
      s1_de        <= 1'b0;
      rgb_out      <= '0;
      hs_out       <= 1'b0;
      vs_out       <= 1'b0;
      de_out       <= 1'b0;
      uflow_cnt    <= '0;
      uflow_sticky <= 1'b0;
      fcnt         <= '0;
      frame_pixels <= '0;
    end else begin
      vs_q        <= vs_in;
      frame_start <= vs_rise;

      unique case (state)
        IDLE:    if (vs_rise) state <= ARM;
        ARM:     if (vs_fall) state <= RUN;
        RUN:     if (vs_rise) state <= ARM;
        default: state <= IDLE;
      endcase

      s1_sel  <= sel_d;
      s1_pix  <= pix.pix_data;
      s1_hs   <= hs_in;
      s1_vs   <= vs_in;
      s1_de   <= pix.pix_ready;
      rgb_out <= rgb_d;
      hs_out  <= s1_hs;
      vs_out  <= s1_vs;
      de_out  <= s1_de;

      if (uflow) begin
        uflow_sticky <= 1'b1;
        if (uflow_cnt != '1) uflow_cnt <= uflow_cnt + CNT_W'(1);
      end

      // only a frame that was fully displayed publishes its size
      if (vs_rise) begin
        if (run) frame_pixels <= fcnt_inc;
        fcnt <= '0;
      end else begin
        fcnt <= fcnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_dvi_pixel_stage.sv
// Bench for dvi_pixel_stage: startup vector table, directed frames with
// underflow gaps, random frames checked against a cycle reference model.
module tb_dvi_pixel_stage;
  localparam int          PIX_W  = 24;
  localparam logic [23:0] BORDER = 24'h000000;
  localparam logic [23:0] UFCOL  = 24'hFF00FF;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        vs_in = 1'b0;
  logic        hs_in = 1'b0;
  logic        border_in = 1'b1;

  logic        fs_a, hs_a, vs_a, de_a, st_a;
  logic [23:0] rgb_a;
  logic [15:0] uf_a;
  logic [19:0] fp_a;
  logic        fs_b, hs_b, vs_b, de_b, st_b;
  logic [23:0] rgb_b;
  logic [1:0]  uf_b;
  logic [19:0] fp_b;

  dvi_pixel_stage_if #(.PIX_W(PIX_W)) pa ();
  dvi_pixel_stage_if #(.PIX_W(PIX_W)) pb ();

  assign pb.pix_data  = pa.pix_data;
  assign pb.pix_valid = pa.pix_valid;

  dvi_pixel_stage dut (
    .clock(clock), .rst(rst), .vs_in(vs_in), .hs_in(hs_in),
    .border_in(border_in), .pix(pa.slave), .frame_start(fs_a),
    .rgb_out(rgb_a), .hs_out(hs_a), .vs_out(vs_a), .de_out(de_a),
    .uflow_cnt(uf_a), .uflow_sticky(st_a), .frame_pixels(fp_a)
  );

  dvi_pixel_stage #(.CNT_W(2)) dut_sat (
    .clock(clock), .rst(rst), .vs_in(vs_in), .hs_in(hs_in),
    .border_in(border_in), .pix(pb.slave), .frame_start(fs_b),
    .rgb_out(rgb_b), .hs_out(hs_b), .vs_out(vs_b), .de_out(de_b),
    .uflow_cnt(uf_b), .uflow_sticky(st_b), .frame_pixels(fp_b)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int de_seen = 0;

  // reference model: 0 idle, 1 waiting for vsync end, 2 displaying
  int          mode = 0;
  bit          vsprev = 0;
  int          ufc = 0;
  bit          sticky = 0;
  int          popc = 0;
  int          fpix = 0;
  bit          fs_exp = 0;
  logic [23:0] e_rgb [4] = '{default: '0};
  bit          e_hs [4] = '{default: 0};
  bit          e_vs [4] = '{default: 0};
  bit          e_de [4] = '{default: 0};

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit v, input bit h, input bit b,
                      input bit val, input logic [23:0] d);
    bit          rise, fall, act, rdy, pop, uf;
    logic [23:0] col;
    int          k;
    @(posedge clock);
    #1;
    rst = r;
    vs_in = v;
    hs_in = h;
    border_in = b;
    pa.pix_valid = val;
    pa.pix_data = d;
    @(negedge clock);
    rise = v && !vsprev;
    fall = !v && vsprev;
    act = !b && !h && !v;
    rdy = (mode == 2) && act;
    pop = rdy && val;
    uf = rdy && !val;
    chk("pix_ready", 64'(pa.pix_ready), 64'(rdy));
    if (cyc >= 3) begin
      k = cyc % 4;
      chk("rgb_out", 64'(rgb_a), 64'(e_rgb[k]));
      chk("hs_out", 64'(hs_a), 64'(e_hs[k]));
      chk("vs_out", 64'(vs_a), 64'(e_vs[k]));
      chk("de_out", 64'(de_a), 64'(e_de[k]));
      chk("frame_start", 64'(fs_a), 64'(fs_exp));
      chk("uflow_cnt", 64'(uf_a), 64'(ufc));
      chk("uflow_sticky", 64'(st_a), 64'(sticky));
      chk("frame_pixels", 64'(fp_a), 64'(fpix));
      chk("sat_uflow_cnt", 64'(uf_b), 64'((ufc > 3) ? 3 : ufc));
      chk("sat_sticky", 64'(st_b), 64'(sticky));
      if (de_a) de_seen++;
    end
    if (r) begin
      mode = 0;
      vsprev = 0;
      ufc = 0;
      sticky = 0;
      popc = 0;
      fpix = 0;
      fs_exp = 0;
      for (int j = 1; j <= 2; j++) begin
        e_rgb[(cyc + j) % 4] = '0;
        e_hs[(cyc + j) % 4] = 0;
        e_vs[(cyc + j) % 4] = 0;
        e_de[(cyc + j) % 4] = 0;
      end
    end else begin
      if (mode == 0) col = '0;
      else if (!rdy) col = BORDER;
      else if (val) col = d;
      else col = UFCOL;
      e_rgb[(cyc + 2) % 4] = col;
      e_hs[(cyc + 2) % 4] = h;
      e_vs[(cyc + 2) % 4] = v;
      e_de[(cyc + 2) % 4] = rdy;
      fs_exp = rise;
      if (uf) begin
        ufc++;
        sticky = 1;
      end
      if (pop) popc++;
      if (rise) begin
        if (mode == 2) fpix = popc;
        popc = 0;
        mode = 1;
      end else if (fall && mode == 1) begin
        mode = 2;
      end
      vsprev = v;
    end
    cyc++;
  endtask

  // one small frame: vsync, porch line, h lines of w pixels, porch line
  task automatic frame(input int w, input int h, input int drop_at,
                       input int drop_n, input bit rnd);
    int k = 0;
    bit val;
    for (int i = 0; i < 3; i++)
      step(0, 1, rnd ? 1'($urandom) : 1'b0, 1, 1, 24'($urandom));
    for (int i = 0; i < w + 4; i++)
      step(0, 0, rnd ? 1'($urandom) : 1'b0, 1, 1, 24'($urandom));
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        if (rnd) val = ($urandom % 4) != 0;
        else val = !(k >= drop_at && k < drop_at + drop_n);
        step(0, 0, 0, 0, val, 24'($urandom));
        k++;
      end
      step(0, 0, 0, 1, 1, 24'($urandom));
      step(0, 0, 0, 1, 1, 24'($urandom));
      step(0, 0, 1, 1, 1, 24'($urandom));
      step(0, 0, 1, 1, 1, 24'($urandom));
    end
    for (int i = 0; i < w + 4; i++)
      step(0, 0, 0, 1, 1, 24'($urandom));
  endtask

  typedef struct {
    bit v;
    bit h;
    bit b;
    bit val;
    bit rdy;
    bit fs;
  } vec_t;

  vec_t tbl [10];

  initial begin
    tbl[0] = '{v: 0, h: 0, b: 1, val: 1, rdy: 0, fs: 0};
    tbl[1] = '{v: 1, h: 0, b: 1, val: 1, rdy: 0, fs: 0};
    tbl[2] = '{v: 1, h: 0, b: 1, val: 1, rdy: 0, fs: 1};
    tbl[3] = '{v: 0, h: 0, b: 1, val: 1, rdy: 0, fs: 0};
    tbl[4] = '{v: 0, h: 0, b: 0, val: 1, rdy: 1, fs: 0};
    tbl[5] = '{v: 0, h: 0, b: 0, val: 0, rdy: 1, fs: 0};
    tbl[6] = '{v: 0, h: 1, b: 0, val: 1, rdy: 0, fs: 0};
    tbl[7] = '{v: 1, h: 0, b: 0, val: 1, rdy: 0, fs: 0};
    tbl[8] = '{v: 0, h: 0, b: 0, val: 1, rdy: 0, fs: 1};
    tbl[9] = '{v: 0, h: 0, b: 0, val: 1, rdy: 1, fs: 0};

    pa.pix_data = '0;
    pa.pix_valid = 1'b0;
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0, '0);
    step(0, 0, 0, 1, 1, '0);
    chk("init_rgb", 64'(rgb_a), 64'(0));
    chk("init_fs", 64'(fs_a), 64'(0));
    chk("init_uflow", 64'(uf_a), 64'(0));

    for (int i = 0; i < 10; i++) begin
      step(0, tbl[i].v, tbl[i].h, tbl[i].b, tbl[i].val, 24'($urandom));
      chk("tbl_ready", 64'(pa.pix_ready), 64'(tbl[i].rdy));
      chk("tbl_fs", 64'(fs_a), 64'(tbl[i].fs));
    end

    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 24'($urandom));
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1, 24'($urandom));
    step(0, 0, 0, 1, 1, '0);
    chk("rst_rgb", 64'(rgb_a), 64'(0));
    chk("rst_de", 64'(de_a), 64'(0));
    chk("rst_fs", 64'(fs_a), 64'(0));
    chk("rst_uflow", 64'(uf_a), 64'(0));
    chk("rst_sticky", 64'(st_a), 64'(0));
    chk("rst_fpix", 64'(fp_a), 64'(0));

    de_seen = 0;
    frame(8, 4, -10, 0, 0);
    chk("frame1_de_cycles", 64'(de_seen), 64'(32));
    frame(8, 4, 10, 3, 0);
    chk("frame2_fpix", 64'(fp_a), 64'(32));
    chk("frame2_uflow", 64'(uf_a), 64'(3));
    chk("frame2_sticky", 64'(st_a), 64'(1));
    frame(8, 4, 0, 5, 0);
    chk("frame3_fpix", 64'(fp_a), 64'(29));
    chk("frame3_uflow", 64'(uf_a), 64'(8));
    chk("sat_hold", 64'(uf_b), 64'(3));

    for (int f = 0; f < 3; f++)
      frame(4 + int'($urandom % 6), 2 + int'($urandom % 3), 0, 0, 1);
    step(0, 1, 0, 1, 1, '0);
    step(0, 1, 0, 1, 1, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
